fetch_fifo: RTL and testbench
=============================

FETCH_FIFO -- requirements
Module: fetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch_entry slots; power of two, minimum 2.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, discards all buffered entries (mispredict/exception).
REQ-005 SHALL have port fetch_entry_i, input, fetch_entry, entry from the fetch stage.
REQ-006 SHALL have port fetch_entry_valid_i, input, 1, fetch_entry_i is valid.
REQ-007 SHALL have port fetch_ready_o, output, 1, the FIFO can accept an entry this cycle.
REQ-008 SHALL have port fetch_entry_o, output, fetch_entry, head entry to the decode stage.
REQ-009 SHALL have port fetch_entry_valid_o, output, 1, fetch_entry_o is valid.
REQ-010 SHALL have port decode_ack_i, input, 1, decode consumes the head entry this cycle.
REQ-011 SHALL have port count_o, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-012 SHALL push when fetch_entry_valid_i && fetch_ready_o && !flush_i.
REQ-013 SHALL pop when decode_ack_i && fetch_entry_valid_o && !flush_i.
REQ-014 SHALL drive fetch_ready_o = (count_o != DEPTH), independent of decode_ack_i; no push into a full FIFO even with a simultaneous pop.
REQ-015 SHALL drive fetch_entry_valid_o = (count_o != 0); no fall-through, so a pushed entry appears at the output the cycle after the push (latency 1).
REQ-016 SHALL drive fetch_entry_o from the storage slot at the read pointer, combinationally; value is don't-care when not valid.
REQ-017 SHALL keep read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH on pop/push.
REQ-018 SHALL update occupancy as follows: push only increments count, pop only decrements it, simultaneous push and pop leave it unchanged.
REQ-019 SHALL ignore decode_ack_i when the FIFO is empty; pointers and count are unchanged.
REQ-020 SHALL, on flush_i, set both pointers and count to 0 next cycle; flush takes priority over any concurrent push or pop, and the concurrent input entry is dropped.
REQ-021 SHALL pass all fetch_entry fields (ex, branch_predict, is_compressed, is_illegal) through unmodified and in order.
REQ-022 SHALL NOT write storage on a non-push cycle; the stored payload need not be reset.

Reset
REQ-023 SHALL, when rst_i is high at a clock edge, set pointers and count to 0, giving fetch_entry_valid_o=0, fetch_ready_o=1, count_o=0 next cycle.
REQ-024 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries.

Structure
REQ-025 SHALL take fetch_entry, exception and branchpredict_sbe from ariane_pkg; no new package types are required.
REQ-026 SHALL add the default depth to ariane_pkg as localparam FETCH_FIFO_DEPTH = 4.
REQ-027 SHALL be a single module with no sub-modules; storage is a register array of DEPTH fetch_entry.

Verification
REQ-028 SHALL cover reset then a single push: push entry address=0x80 into an empty FIFO -> valid_o=1 the next cycle with address 0x80 and count_o=1; ack -> valid_o=0 and count_o=0.
REQ-029 SHALL cover fill to full: push addresses 0x0,0x4,0x8,0xC with no ack -> ready_o=0 and count_o=4; a fifth push with ack high -> the fifth entry is dropped, count_o=3, head=0x4.
REQ-030 SHALL cover wrap-around: 10 consecutive cycles of simultaneous push and ack with count 2 -> count_o stays 2 and output order matches input order across pointer wrap.
REQ-031 SHALL cover flush priority: FIFO holds 3 entries, flush_i, push and ack in the same cycle -> next cycle count_o=0, valid_o=0, ready_o=1, pushed entry lost.
REQ-032 SHALL cover exception pass-through: push entry with ex.valid=1, ex.cause=INSTR_ACCESS_FAULT, ex.tval=0x1000 -> output carries identical ex fields.
REQ-033 SHALL cover reset mid-stream: 2 entries buffered, rst_i high together with push -> next cycle count_o=0, valid_o=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared frontend types used by the fetch FIFO.
//   exception         - trap cause/value carried alongside an instruction
//   branchpredict_sbe - branch prediction info forwarded to the scoreboard
//   fetch_entry       - one fetched instruction plus its side information
//   FETCH_FIFO_DEPTH  - default number of fetch_entry slots in fetch_fifo
package ariane_pkg;

    localparam int unsigned FETCH_FIFO_DEPTH = 4;

    localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
    localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
    localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        is_lower_16;
    } branchpredict_sbe;

    typedef struct packed {
        logic [63:0]      address;
        logic [31:0]      instruction;
        branchpredict_sbe branch_predict;
        exception         ex;
        logic             is_compressed;
        logic             is_illegal;
    } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: decouples the fetch stage from decode with a small circular buffer.
// Ports:
//   clk_i               - clock, all state updates on its rising edge
//   rst_i               - synchronous active-high reset (beats flush, push, pop)
//   flush_i             - drop every buffered entry and any entry offered this cycle
//   fetch_entry_i       - entry from fetch
//   fetch_entry_valid_i - fetch_entry_i is valid
//   fetch_ready_o       - FIFO not full; an entry can be accepted
//   fetch_entry_o       - head entry to decode (don't-care when not valid)
//   fetch_entry_valid_o - FIFO not empty
//   decode_ack_i        - decode consumes the head entry this cycle
//   count_o             - current occupancy, 0..DEPTH
// No fall-through: an entry pushed this cycle is visible at the head next cycle.
module fetch_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  fetch_entry                 fetch_entry_i,
    input  logic                       fetch_entry_valid_i,
    output logic                       fetch_ready_o,
    output fetch_entry                 fetch_entry_o,
    output logic                       fetch_entry_valid_o,
    input  logic                       decode_ack_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on occupancy, so a full FIFO refuses a push even
    // when decode frees a slot in the same cycle.
    assign fetch_ready_o       = (count_o != FULL_CNT);
    assign fetch_entry_valid_o = (count_o != '0);
    assign fetch_entry_o       = mem[rd_ptr];

    assign push = fetch_entry_valid_i && fetch_ready_o && !flush_i;
    assign pop  = decode_ack_i && fetch_entry_valid_o && !flush_i;

    // Payload is not reset; only written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= fetch_entry_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + (PTR_W + 1)'(1);
                2'b01:   count_o <= count_o - (PTR_W + 1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_fifo.sv
// tb_fetch_fifo: directed self-checking bench for fetch_fifo (DEPTH = 4).
module tb_fetch_fifo;
    import ariane_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    fetch_entry fetch_entry_i;
    logic       fetch_entry_valid_i;
    logic       fetch_ready_o;
    fetch_entry fetch_entry_o;
    logic       fetch_entry_valid_o;
    logic       decode_ack_i;
    logic [2:0] count_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_fifo #(.DEPTH(4)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_ready_o       (fetch_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .decode_ack_i        (decode_ack_i),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic fetch_entry mk(input logic [63:0] addr);
        fetch_entry e;
        e             = '0;
        e.address     = addr;
        e.instruction = addr[31:0] ^ 32'h0000_0013;
        return e;
    endfunction

    // Apply inputs just after an edge, then advance past the next rising edge.
    task automatic cycle(input logic v, input logic [63:0] addr, input logic ack,
                         input logic fl, input logic rs);
        fetch_entry_valid_i = v;
        fetch_entry_i       = mk(addr);
        decode_ack_i        = ack;
        flush_i             = fl;
        rst_i               = rs;
        @(posedge clk_i);
        #1;
        fetch_entry_valid_i = 1'b0;
        decode_ack_i        = 1'b0;
        flush_i             = 1'b0;
        rst_i               = 1'b0;
    endtask

    initial begin
        fetch_entry ex_e;
        fetch_entry_i       = '0;
        fetch_entry_valid_i = 1'b0;
        decode_ack_i        = 1'b0;
        flush_i             = 1'b0;
        rst_i               = 1'b1;
        @(posedge clk_i);
        #1;
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);

        // single push, latency one
        fetch_entry_valid_i = 1'b1;
        fetch_entry_i       = mk(64'h80);
        #1;
        check("no_fallthrough", 64'(fetch_entry_valid_o), 64'd0);
        cycle(1'b1, 64'h80, 1'b0, 1'b0, 1'b0);
        check("single_valid", 64'(fetch_entry_valid_o), 64'd1);
        check("single_addr", fetch_entry_o.address, 64'h80);
        check("single_count", 64'(count_o), 64'd1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("single_pop_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("single_pop_count", 64'(count_o), 64'd0);

        // fill to full
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(4 * i), 1'b0, 1'b0, 1'b0);
        check("full_ready", 64'(fetch_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'd4);
        check("full_head", fetch_entry_o.address, 64'h0);
        cycle(1'b1, 64'h10, 1'b1, 1'b0, 1'b0);
        check("full_push_ack_count", 64'(count_o), 64'd3);
        check("full_push_ack_head", fetch_entry_o.address, 64'h4);
        check("full_push_ack_ready", 64'(fetch_ready_o), 64'd1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("drain_head1", fetch_entry_o.address, 64'h8);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("drain_head2", fetch_entry_o.address, 64'hC);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("drain_count", 64'(count_o), 64'd0);
        check("drain_valid", 64'(fetch_entry_valid_o), 64'd0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("empty_ack_count", 64'(count_o), 64'd0);
        check("empty_ack_valid", 64'(fetch_entry_valid_o), 64'd0);

        // wrap-around with steady count 2
        cycle(1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h104, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("wrap_head", fetch_entry_o.address, 64'h100 + 64'(4 * i));
            cycle(1'b1, 64'h108 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
            check("wrap_count", 64'(count_o), 64'd2);
        end
        check("wrap_tail0", fetch_entry_o.address, 64'h128);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_tail1", fetch_entry_o.address, 64'h12C);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_empty", 64'(count_o), 64'd0);

        // exception and side-field pass-through
        ex_e                                = mk(64'h1000);
        ex_e.ex.valid                       = 1'b1;
        ex_e.ex.cause                       = INSTR_ACCESS_FAULT;
        ex_e.ex.tval                        = 64'h1000;
        ex_e.branch_predict.valid           = 1'b1;
        ex_e.branch_predict.predict_address = 64'hDEAD_BEE0;
        ex_e.branch_predict.predict_taken   = 1'b1;
        ex_e.is_compressed                  = 1'b1;
        ex_e.is_illegal                     = 1'b1;
        fetch_entry_valid_i = 1'b1;
        fetch_entry_i       = ex_e;
        @(posedge clk_i);
        #1;
        fetch_entry_valid_i = 1'b0;
        check("ex_valid", 64'(fetch_entry_o.ex.valid), 64'd1);
        check("ex_cause", fetch_entry_o.ex.cause, 64'd1);
        check("ex_tval", fetch_entry_o.ex.tval, 64'h1000);
        check("bp_addr", fetch_entry_o.branch_predict.predict_address, 64'hDEAD_BEE0);
        check("bp_taken", 64'(fetch_entry_o.branch_predict.predict_taken), 64'd1);
        check("is_compressed", 64'(fetch_entry_o.is_compressed), 64'd1);
        check("is_illegal", 64'(fetch_entry_o.is_illegal), 64'd1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // flush beats concurrent push and ack
        cycle(1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h204, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h208, 1'b0, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count_o), 64'd3);
        cycle(1'b1, 64'h20C, 1'b1, 1'b1, 1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("flush_ready", 64'(fetch_ready_o), 64'd1);
        cycle(1'b1, 64'h300, 1'b0, 1'b0, 1'b0);
        check("post_flush_head", fetch_entry_o.address, 64'h300);
        check("post_flush_count", 64'(count_o), 64'd1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // reset mid-stream beats push
        cycle(1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h404, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count_o), 64'd2);
        cycle(1'b1, 64'h408, 1'b0, 1'b0, 1'b1);
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("mid_rst_ready", 64'(fetch_ready_o), 64'd1);
        cycle(1'b1, 64'h500, 1'b0, 1'b0, 1'b0);
        check("post_rst_head", fetch_entry_o.address, 64'h500);
        check("post_rst_count", 64'(count_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
